// File: rtl/touch_pkg.sv
// -----------------------------------------------------------------------------
// touch_pkg
// Shared types for the touch scan controller: per-channel FSM state encoding,
// event codes, the {chan, code} event record and a channel-index width helper.
// -----------------------------------------------------------------------------
package touch_pkg;

  // Widest channel index needed for the largest supported channel count (16).
  localparam int MAX_CH_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS_DB  = 3'd1,
    ST_HELD      = 3'd2,
    ST_LONG_HELD = 3'd3,
    ST_REL_DB    = 3'd4
  } chan_state_e;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_code_e;

  typedef struct packed {
    logic [MAX_CH_W-1:0] chan;
    evt_code_e           code;
  } evt_t;

  // Channel index width; a single channel still gets a 1-bit index.
  function automatic int chan_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/touch_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// touch_scan_ctrl_if
// Event handshake between the scan controller (master) and its consumer (slave).
//   evt_valid  master->slave  event available
//   evt_ready  slave->master  consumer takes the event when evt_valid is high
//   evt_chan   master->slave  channel index of the event
//   evt_code   master->slave  PRESS=1, LONG=2, RELEASE=3
// -----------------------------------------------------------------------------
interface touch_scan_ctrl_if
  import touch_pkg::*;
#(
  parameter int NCH = 4
);
  localparam int CHW = chan_w(NCH);

  logic           evt_valid;
  logic           evt_ready;
  logic [CHW-1:0] evt_chan;
  logic [1:0]     evt_code;

  modport master (output evt_valid, evt_chan, evt_code, input  evt_ready);
  modport slave  (input  evt_valid, evt_chan, evt_code, output evt_ready);

endinterface

// File: rtl/touch_chan_fsm.sv
// -----------------------------------------------------------------------------
// touch_chan_fsm
// One touch channel: 2-flop synchronizer, press/release debounce and long-press
// timing. Emits a one-cycle event code in the cycle before the edge on which the
// corresponding state transition happens, so the parent can capture it on
// that same edge.
//   clk, rst_n   clock, asynchronous active-low reset
//   raw_i        asynchronous raw sensor level (1 = touched)
//   en_i         channel enable; low forces IDLE and suppresses events
//   touched_o    debounced touch state
//   evt_code_o   event raised by the pending transition (EVT_NONE otherwise)
// -----------------------------------------------------------------------------
module touch_chan_fsm
  import touch_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int LONG_CYC     = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      raw_i,
  input  logic      en_i,
  output logic      touched_o,
  output evt_code_e evt_code_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);

  logic              sync_meta_q, sync_q;
  chan_state_e       state_q, state_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_q, long_d;   // LONG already raised for this press

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      state_q     <= ST_IDLE;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_q      <= 1'b0;
    end else begin
      sync_meta_q <= raw_i;
      sync_q      <= sync_meta_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_q      <= long_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    long_d     = long_q;
    evt_code_o = EVT_NONE;

    if (!en_i) begin
      state_d    = ST_IDLE;
      db_cnt_d   = '0;
      hold_cnt_d = '0;
      long_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sync_q) begin
            state_d  = ST_PRESS_DB;
            db_cnt_d = DB_ONE;
          end
        end
        ST_PRESS_DB: begin
          if (!sync_q) begin
            state_d  = ST_IDLE;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            // This sample is the DEBOUNCE_CYC-th consecutive high one.
            state_d    = ST_HELD;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            evt_code_o = EVT_PRESS;
          end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end
        end
        ST_HELD: begin
          if (!sync_q) begin
            state_d  = ST_REL_DB;
            db_cnt_d = DB_ONE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_d    = ST_LONG_HELD;
            long_d     = 1'b1;
            evt_code_o = EVT_LONG;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_ONE;
          end
        end
        ST_LONG_HELD: begin
          if (!sync_q) begin
            state_d  = ST_REL_DB;
            db_cnt_d = DB_ONE;
          end
        end
        ST_REL_DB: begin
          if (sync_q) begin
            // Release glitch: resume where we left off, hold count untouched.
            state_d  = long_q ? ST_LONG_HELD : ST_HELD;
            db_cnt_d = '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_d    = ST_IDLE;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            long_d     = 1'b0;
            evt_code_o = EVT_RELEASE;
          end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign touched_o = (state_q == ST_HELD) || (state_q == ST_LONG_HELD) ||
                     (state_q == ST_REL_DB);

endmodule

// File: rtl/touch_scan_ctrl.sv
// -----------------------------------------------------------------------------
// touch_scan_ctrl
// Multi-channel touch scanner. Each channel runs a touch_chan_fsm; raised events
// land in a 1-entry pending slot per channel, and a round-robin arbiter moves
// them into a single valid/ready output register.
//   clk, rst_n   clock, asynchronous active-low reset
//   touch_raw    asynchronous raw sensor levels (1 = touched)
//   ch_en        per-channel enable
//   touched      debounced touch state per channel
//   ovf          sticky: an event was dropped because its slot was full
//   clr_ovf      synchronous clear of ovf (a same-cycle drop wins)
//   evt          event handshake (master side)
// -----------------------------------------------------------------------------
module touch_scan_ctrl
  import touch_pkg::*;
#(
  parameter int NCH          = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int LONG_CYC     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        touch_raw,
  input  logic [NCH-1:0]        ch_en,
  output logic [NCH-1:0]        touched,
  output logic                  ovf,
  input  logic                  clr_ovf,
  touch_scan_ctrl_if.master     evt
);

  localparam int CHW = chan_w(NCH);

  evt_code_e      ch_evt [NCH];

  logic [NCH-1:0] pend_valid_q, pend_valid_d;
  evt_code_e      pend_code_q [NCH];
  evt_code_e      pend_code_d [NCH];

  logic           out_valid_q, out_valid_d;
  evt_t           out_q, out_d;
  logic [CHW-1:0] last_grant_q, last_grant_d;
  logic           ovf_q, ovf_d;

  logic           load;
  logic           grant_any;
  logic [CHW-1:0] grant_idx;
  logic [CHW-1:0] scan_idx;
  logic [NCH-1:0] grant_vec;
  logic           drop;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    touch_chan_fsm #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_i      (touch_raw[g]),
      .en_i       (ch_en[g]),
      .touched_o  (touched[g]),
      .evt_code_o (ch_evt[g])
    );
  end

  // Channel index `step` positions after `base`, wrapping at NCH.
  function automatic logic [CHW-1:0] rr_step(logic [CHW-1:0] base, int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NCH) sum = sum - NCH;
    return CHW'(sum);
  endfunction

  // Arbiter: the output register takes a new event when it is empty or its
  // current one is being consumed; scan starts just after the last grant.
  always_comb begin
    load      = !out_valid_q || evt.evt_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    grant_vec = '0;
    if (load) begin
      for (int k = 1; k <= NCH; k++) begin
        scan_idx = rr_step(last_grant_q, k);
        if (!grant_any && pend_valid_q[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
    if (grant_any) grant_vec[grant_idx] = 1'b1;
  end

  // Pending slots: a slot emptied by this edge's grant can take a new event
  // from the same channel on that edge; an occupied, ungranted slot drops it.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    drop         = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (grant_vec[i]) pend_valid_d[i] = 1'b0;
      if (ch_evt[i] != EVT_NONE) begin
        if (pend_valid_q[i] && !grant_vec[i]) begin
          drop = 1'b1;
        end else begin
          pend_valid_d[i] = 1'b1;
          pend_code_d[i]  = ch_evt[i];
        end
      end
    end
  end

  // Output register and sticky overflow.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    last_grant_d = last_grant_q;
    if (load) begin
      out_valid_d = grant_any;
      if (grant_any) begin
        out_d.chan   = MAX_CH_W'(grant_idx);
        out_d.code   = pend_code_q[grant_idx];
        last_grant_d = grant_idx;
      end
    end
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // NOTE: the pending slots form a small register array that is reset
  // element by element, because a queued event must not survive reset;
  // large data memories would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= '0;
      for (int i = 0; i < NCH; i++) pend_code_q[i] <= EVT_NONE;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      last_grant_q <= CHW'(NCH - 1);
      ovf_q        <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
      for (int i = 0; i < NCH; i++) pend_code_q[i] <= pend_code_d[i];
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt.evt_valid = out_valid_q;
  assign evt.evt_chan  = out_q.chan[CHW-1:0];
  assign evt.evt_code  = out_q.code;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_touch_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_touch_scan_ctrl
// Directed bench for touch_scan_ctrl with NCH=4, DEBOUNCE_CYC=4, LONG_CYC=16.
// "Edge e" counts rising clock edges after stimulus is applied; outputs are
// sampled 1 time unit after each edge.
// -----------------------------------------------------------------------------
module tb_touch_scan_ctrl;
  import touch_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] touch_raw;
  logic [3:0] ch_en;
  logic [3:0] touched;
  logic       ovf;
  logic       clr_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  touch_scan_ctrl_if #(.NCH(4)) evt_if ();

  touch_scan_ctrl #(
    .NCH          (4),
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch_raw (touch_raw),
    .ch_en     (ch_en),
    .touched   (touched),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf),
    .evt       (evt_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted handshake, sampled mid-cycle.
  evt_t seen_q[$];
  evt_t mon_e;
  always @(negedge clk) begin
    if (rst_n && evt_if.evt_valid && evt_if.evt_ready) begin
      mon_e.chan = 4'(evt_if.evt_chan);
      mon_e.code = evt_code_e'(evt_if.evt_code);
      seen_q.push_back(mon_e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    touch_raw        = '0;
    ch_en            = '1;
    clr_ovf          = 1'b0;
    evt_if.evt_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    seen_q.delete();
  endtask

  task automatic test_reset();
    rst_n            = 1'b1;
    touch_raw        = '0;
    ch_en            = '1;
    clr_ovf          = 1'b0;
    evt_if.evt_ready = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    n_cmp++; if (touched !== 4'b0) begin n_bad++; $display("FAIL reset_touched: got %b want 0000", touched); end
    n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", evt_if.evt_valid); end
    n_cmp++; if (evt_if.evt_chan !== 2'd0) begin n_bad++; $display("FAIL reset_chan: got %0d want 0", evt_if.evt_chan); end
    n_cmp++; if (evt_if.evt_code !== 2'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", evt_if.evt_code); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
  endtask

  // 3 cycles of high input is one sample short of debounce: no event.
  task automatic test_short_touch();
    do_reset();
    evt_if.evt_ready = 1'b1;
    touch_raw[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) touch_raw[0] = 1'b0;
      n_cmp++;
      if ({touched, evt_if.evt_valid} !== 5'b0) begin
        n_bad++;
        $display("FAIL short_touch e=%0d: touched=%b valid=%b want 0000/0", e, touched, evt_if.evt_valid);
      end
    end
  endtask

  // Disabled channel never debounces or reports.
  task automatic test_disable();
    do_reset();
    ch_en = 4'b1110;
    evt_if.evt_ready = 1'b1;
    touch_raw[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_cmp++;
      if ({touched, evt_if.evt_valid} !== 5'b0) begin
        n_bad++;
        $display("FAIL disable e=%0d: touched=%b valid=%b want 0000/0", e, touched, evt_if.evt_valid);
      end
    end
  endtask

  // PRESS recorded at edge 6, visible after edge 7 for one cycle; input falls
  // after edge 10 so RELEASE is recorded at edge 16 and visible after edge 17.
  task automatic test_press_release();
    logic exp_valid;
    logic [3:0] exp_touched;
    do_reset();
    evt_if.evt_ready = 1'b1;
    touch_raw[1] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_valid   = (e == 7) || (e == 17);
      exp_touched = (e >= 6 && e <= 15) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (evt_if.evt_valid !== exp_valid) begin
        n_bad++;
        $display("FAIL press_rel_valid e=%0d: got %b want %b", e, evt_if.evt_valid, exp_valid);
      end
      n_cmp++;
      if (touched !== exp_touched) begin
        n_bad++;
        $display("FAIL press_rel_touched e=%0d: got %b want %b", e, touched, exp_touched);
      end
      if (e == 7 || e == 17) begin
        n_cmp++;
        if (evt_if.evt_chan !== 2'd1 || evt_if.evt_code !== ((e == 7) ? 2'd1 : 2'd3)) begin
          n_bad++;
          $display("FAIL press_rel_evt e=%0d: chan=%0d code=%0d want chan=1 code=%0d",
                   e, evt_if.evt_chan, evt_if.evt_code, (e == 7) ? 1 : 3);
        end
      end
      if (e == 10) touch_raw[1] = 1'b0;
    end
  endtask

  // 40-cycle hold with a 2-cycle glitch: PRESS, LONG, RELEASE, touched steady.
  task automatic test_long_glitch();
    logic exp_t;
    do_reset();
    evt_if.evt_ready = 1'b1;
    touch_raw[2] = 1'b1;
    for (int e = 1; e <= 55; e++) begin
      tick();
      exp_t = (e >= 6 && e <= 45);
      n_cmp++;
      if (touched[2] !== exp_t) begin
        n_bad++;
        $display("FAIL long_touched e=%0d: got %b want %b", e, touched[2], exp_t);
      end
      if (e == 20) touch_raw[2] = 1'b0;
      if (e == 22) touch_raw[2] = 1'b1;
      if (e == 40) touch_raw[2] = 1'b0;
    end
    n_cmp++;
    if (seen_q.size() != 3) begin
      n_bad++;
      $display("FAIL long_count: got %0d events want 3", seen_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (seen_q[k].chan !== 4'd2 || seen_q[k].code !== evt_code_e'(k + 1)) begin
          n_bad++;
          $display("FAIL long_evt%0d: chan=%0d code=%0d want chan=2 code=%0d",
                   k, seen_q[k].chan, seen_q[k].code, k + 1);
        end
      end
    end
  endtask

  // All four press together under a stall: round-robin 0,1,2,3, stable output.
  task automatic test_back_to_back();
    logic exp_valid;
    int   exp_chan;
    do_reset();
    touch_raw = 4'hf;
    for (int e = 1; e <= 16; e++) begin
      tick();
      exp_valid = (e >= 7 && e <= 13);
      exp_chan  = (e <= 10) ? 0 : e - 10;
      n_cmp++;
      if (evt_if.evt_valid !== exp_valid) begin
        n_bad++;
        $display("FAIL b2b_valid e=%0d: got %b want %b", e, evt_if.evt_valid, exp_valid);
      end
      if (exp_valid) begin
        n_cmp++;
        if (evt_if.evt_chan !== 2'(exp_chan) || evt_if.evt_code !== 2'd1) begin
          n_bad++;
          $display("FAIL b2b_evt e=%0d: chan=%0d code=%0d want chan=%0d code=1",
                   e, evt_if.evt_chan, evt_if.evt_code, exp_chan);
        end
      end
      if (e == 10) evt_if.evt_ready = 1'b1;
    end
  endtask

  // Press, release, press on ch3 with no consumer: second PRESS is dropped.
  task automatic test_overflow();
    do_reset();
    touch_raw[3] = 1'b1;
    for (int e = 1; e <= 34; e++) begin
      tick();
      if (e == 23 || e == 24 || e == 31 || e == 32) begin
        n_cmp++;
        if (ovf !== ((e == 24 || e == 31) ? 1'b1 : 1'b0)) begin
          n_bad++;
          $display("FAIL ovf e=%0d: got %b want %b", e, ovf, (e == 24 || e == 31));
        end
      end
      if (e == 25) begin
        n_cmp++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_chan !== 2'd3 || evt_if.evt_code !== 2'd1) begin
          n_bad++;
          $display("FAIL ovf_stall: valid=%b chan=%0d code=%0d want 1/3/1",
                   evt_if.evt_valid, evt_if.evt_chan, evt_if.evt_code);
        end
      end
      if (e == 10) touch_raw[3] = 1'b0;
      if (e == 18) touch_raw[3] = 1'b1;
      if (e == 25) evt_if.evt_ready = 1'b1;
      if (e == 31) clr_ovf = 1'b1;
      if (e == 32) clr_ovf = 1'b0;
    end
    n_cmp++;
    if (seen_q.size() != 2) begin
      n_bad++;
      $display("FAIL ovf_count: got %0d events want 2", seen_q.size());
    end else begin
      n_cmp++;
      if (seen_q[0].chan !== 4'd3 || seen_q[0].code !== EVT_PRESS ||
          seen_q[1].chan !== 4'd3 || seen_q[1].code !== EVT_RELEASE) begin
        n_bad++;
        $display("FAIL ovf_order: got %0d/%0d then %0d/%0d want 3/1 then 3/3",
                 seen_q[0].chan, seen_q[0].code, seen_q[1].chan, seen_q[1].code);
      end
    end
  endtask

  // Reset while an event is waiting and ch1 is held; press comes back later.
  task automatic test_reset_mid();
    logic exp_valid;
    do_reset();
    touch_raw[1] = 1'b1;
    tick(9);
    n_cmp++;
    if (evt_if.evt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre: valid got %b want 1", evt_if.evt_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (evt_if.evt_valid !== 1'b0 || touched !== 4'b0) begin
      n_bad++;
      $display("FAIL midrst_async: valid=%b touched=%b want 0/0000", evt_if.evt_valid, touched);
    end
    tick(2);
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp_valid = (e >= 7);
      n_cmp++;
      if (evt_if.evt_valid !== exp_valid) begin
        n_bad++;
        $display("FAIL midrst_valid e=%0d: got %b want %b", e, evt_if.evt_valid, exp_valid);
      end
    end
    n_cmp++;
    if (evt_if.evt_chan !== 2'd1 || evt_if.evt_code !== 2'd1 || ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_evt: chan=%0d code=%0d ovf=%b want 1/1/0",
               evt_if.evt_chan, evt_if.evt_code, ovf);
    end
  endtask

  initial begin
    test_reset();
    test_short_touch();
    test_disable();
    test_press_release();
    test_long_glitch();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
